// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch FSM driving a synchronous RAM and presenting each
// fetched word downstream through a single-entry valid/ready holding register.
module fetch_unit #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100,
  parameter int PC_STEP = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] pc, pc_d;
  logic cap;
  assign mem_we = 1'b0;
  assign busy = (state == ISSUE) || (state == WAIT);
  always_comb begin
    state_d = state;
    pc_d = pc;
    cap = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      state_d = start ? ISSUE : IDLE;
    end else begin
      case (state)
        IDLE: state_d = start ? ISSUE : IDLE;
        ISSUE: state_d = WAIT;
        WAIT: begin
          state_d = HOLD;
          pc_d = pc + ADDR_WIDTH'(PC_STEP);
          cap = 1'b1;
        end
        default: state_d = ir_ready ? (start ? ISSUE : IDLE) : HOLD;
      endcase
    end
  end
  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      mem_addr <= '0;
      mem_cs <= 1'b0;
      mem_oe <= 1'b0;
      ir_data <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      mem_addr <= (state_d == ISSUE) ? pc_d : mem_addr;
      mem_cs <= (state_d == ISSUE) || (state_d == WAIT);
      mem_oe <= (state_d == ISSUE) || (state_d == WAIT);
      ir_valid <= (state_d == HOLD);
      ir_data <= cap ? mem_rdata : ir_data;
      ir_pc <= cap ? pc : ir_pc;
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Hardware instruction-fetch stage that sits between single_port_sync_ram_large and the decode/execute control.
- Owns the PC and drives the RAM address/control pins.
- Captures each instruction word and presents it downstream through a valid/ready handshake with a single-entry holding register.
- Accepts PC redirects from execute for jump, skip and halt (halt = redirect to the same PC).

Parameters:
ADDR_WIDTH, 28, RAM address and PC width
DATA_WIDTH, 32, instruction word width
RESET_PC, 'h100, PC value after reset
PC_STEP, 2, PC increment per fetched instruction

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; fetching is enabled while high
mem_addr  output  ADDR_WIDTH  RAM address
mem_cs  output  1  RAM chip select
mem_we  output  1  RAM write enable; constant 0
mem_oe  output  1  RAM output enable
mem_rdata  input  DATA_WIDTH  RAM read data
ir_data  output  DATA_WIDTH  fetched instruction
ir_pc  output  ADDR_WIDTH  address of ir_data
ir_valid  output  1  ir_data/ir_pc are valid
ir_ready  input  1  downstream accepts the instruction
redirect_valid  input  1  one-cycle pulse; load redirect_pc
redirect_pc  input  ADDR_WIDTH  new fetch address
busy  output  1  high in ISSUE or WAIT

Behaviour:
Reset:
- Asynchronous on rst_n low: state=IDLE, pc=RESET_PC.
- ir_valid=0, ir_data=0, ir_pc=0, mem_addr=0, mem_cs=0, mem_oe=0, mem_we=0, busy=0.
- Reset applies immediately, including mid-fetch; the in-flight read is abandoned.
- The first fetch after reset release waits for start.

Outputs are registered. States:
- IDLE: cs=0, oe=0. If start=1 at the edge -> ISSUE.
- ISSUE: mem_addr=pc, cs=1, oe=1. Next edge -> WAIT.
- WAIT: addr/cs/oe held. At the edge:
  - ir_data<=mem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+PC_STEP.
  - -> HOLD.
- HOLD: cs=0, oe=0, ir_valid=1, ir_data/ir_pc stable. At an edge with ir_ready=1 (handshake):
  - ir_valid<=0.
  - -> ISSUE if start=1, else IDLE.
  - With ir_ready=0, hold indefinitely; pc does not advance.

Latency and throughput:
- start high at edge N gives ir_valid high after edge N+2.
- With ir_ready held high, one instruction every 3 cycles.

PC arithmetic:
- ADDR_WIDTH bits, unsigned, wraps modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-2 + 2 -> 0).
- No alignment check; redirect_pc is used as given.

Redirect (highest priority, any state):
- pc<=redirect_pc, ir_valid<=0, state -> ISSUE if start=1 else IDLE.
- In WAIT, the captured word is discarded and pc is not incremented.
- In HOLD with a simultaneous handshake, the instruction counts as consumed; the pc from the redirect wins.
- A redirect in ISSUE restarts at ISSUE with the new pc.

start handling:
- Deasserting start never aborts a fetch; the word is captured and held.
- The FSM then goes to IDLE after the handshake.

Constraints:
- mem_we never asserts.
- mem_cs and mem_oe are always equal.

Test Plan:
- Sequential fetch: RAM 'h100='h1000011E, 'h102='h00000120; reset, start=1, ir_ready=1 -> ir_valid 2 edges after start, ir_data='h1000011E, ir_pc='h100. Then 3 cycles later 'h00000120/'h102. mem_we=0 throughout.
- Backpressure: ir_ready=0 for 5 cycles while in HOLD -> ir_data and ir_pc stable, mem_cs=0, pc stays 'h102. Releasing ready gives a handshake and the next fetch at 'h102.
- Redirect in WAIT: redirect_pc='h11A (RAM 'h11A='h7800000A) -> first word discarded; next ir_valid shows ir_data='h7800000A, ir_pc='h11A.
- Redirect coincident with handshake in HOLD: redirect_pc='h100 -> no duplicate ir_valid; next instruction ir_pc='h100.
- Wrap and start drop: redirect to 'hFFFFFFE with start=1, then drop start after ISSUE -> word at 'hFFFFFFE delivered, pc=0, FSM returns to IDLE with cs=0.
- Async reset mid-WAIT: rst_n low between edges -> all outputs zero immediately (before the next edge), pc='h100 on release, no ir_valid until start.
